// File: rtl/game_timer.sv
`timescale 1ns/1ps
// game_timer: divides CLOCK50M down to a game tick and keeps a tick counter.
// The counter runs up or down, saturates or wraps at its terminal value, and
// pulses `expired` when it reaches that value. Write requests are latched and
// re-emitted as one strobe aligned to the next tick.
//
// Ports:
//   CLOCK50M        system clock
//   KEY0            synchronous active-high reset
//   en              run enable (0 freezes the prescaler and the counter)
//   speed           tick period = TICK_DIV >> speed
//   mode_down       0 = count up, 1 = count down (sampled on tick cycles)
//   wrap_en         1 = wrap at terminal value, 0 = saturate (sampled on ticks)
//   load, load_val  synchronous counter load; discards a coincident tick
//   write           write request of any length
//   counter_out     game counter
//   counter_update  1-cycle pulse on every tick
//   write_tick      1-cycle pulse on a tick that services a write request
//   expired         1-cycle pulse when a tick hits the terminal value
module game_timer #(
    parameter int unsigned TICK_DIV = 5000000,
    parameter int unsigned DIV_W    = 23,
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned SPEED_W  = 2,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic               CLOCK50M,
    input  logic               KEY0,
    input  logic               en,
    input  logic [SPEED_W-1:0] speed,
    input  logic               mode_down,
    input  logic               wrap_en,
    input  logic               load,
    input  logic [CNT_W-1:0]   load_val,
    input  logic               write,
    output logic [CNT_W-1:0]   counter_out,
    output logic               counter_update,
    output logic               write_tick,
    output logic               expired
);

    localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};

    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] period_c;
    logic [DIV_W-1:0] term_c;
    logic             tick_c;
    logic             pending;
    logic             at_term_c;
    logic [CNT_W-1:0] cnt_next_c;

    // Tick decision; >= lets a switch to a faster speed tick immediately.
    always_comb begin
        period_c = DIV_W'(TICK_DIV) >> speed;
        term_c   = period_c - DIV_W'(1);
        tick_c   = en && (presc >= term_c);
    end

    // Counter value that a tick would produce.
    always_comb begin
        at_term_c  = mode_down ? (counter_out == '0) : (counter_out == CNT_ONES);
        cnt_next_c = mode_down ? (counter_out - CNT_W'(1)) : (counter_out + CNT_W'(1));
        if (at_term_c) begin
            if (wrap_en) begin
                cnt_next_c = mode_down ? CNT_ONES : '0;
            end else begin
                cnt_next_c = counter_out;
            end
        end
    end

    // Prescaler, counter, pending write flag and output pulses.
    always_ff @(posedge CLOCK50M) begin
        if (KEY0) begin
            presc          <= '0;
            counter_out    <= CNT_W'(RST_VAL);
            pending        <= 1'b0;
            counter_update <= 1'b0;
            write_tick     <= 1'b0;
            expired        <= 1'b0;
        end else begin
            counter_update <= 1'b0;
            write_tick     <= 1'b0;
            expired        <= 1'b0;
            if (write) begin
                pending <= 1'b1;
            end
            if (load) begin
                // Load wins over a coincident tick; the pending write survives.
                counter_out <= load_val;
                presc       <= '0;
            end else if (tick_c) begin
                presc          <= '0;
                counter_out    <= cnt_next_c;
                counter_update <= 1'b1;
                expired        <= at_term_c;
                // A write on the tick cycle is serviced here, not carried over.
                if (pending || write) begin
                    write_tick <= 1'b1;
                    pending    <= 1'b0;
                end
            end else if (en) begin
                presc <= presc + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_game_timer.sv
`timescale 1ns/1ps
module tb_game_timer;

    logic       CLOCK50M = 1'b0;
    logic       KEY0;
    logic       en;
    logic [1:0] speed;
    logic       mode_down;
    logic       wrap_en;
    logic       load;
    logic [3:0] load_val;
    logic       write;
    logic [3:0] counter_out;
    logic       counter_update;
    logic       write_tick;
    logic       expired;

    always #10 CLOCK50M = ~CLOCK50M;

    game_timer #(
        .TICK_DIV(8),
        .DIV_W   (4),
        .CNT_W   (4),
        .SPEED_W (2),
        .RST_VAL (0)
    ) dut (
        .CLOCK50M      (CLOCK50M),
        .KEY0          (KEY0),
        .en            (en),
        .speed         (speed),
        .mode_down     (mode_down),
        .wrap_en       (wrap_en),
        .load          (load),
        .load_val      (load_val),
        .write         (write),
        .counter_out   (counter_out),
        .counter_update(counter_update),
        .write_tick    (write_tick),
        .expired       (expired)
    );

    // One observed/expected tick event: counter value, pulses, cycles waited
    // since the previous observation point, and stray pulses seen meanwhile.
    typedef struct packed {
        logic [3:0] cnt;
        logic       ex;
        logic       wt;
        logic [7:0] gap;
        logic [7:0] stray;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK50M);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] c, input logic ex, input logic wt, input int gap);
        ev_t e;
        e.cnt   = c;
        e.ex    = ex;
        e.wt    = wt;
        e.gap   = 8'(gap);
        e.stray = 8'd0;
        exp_q.push_back(e);
    endtask

    // Observation only: waits (bounded) for the next counter_update.
    task automatic wait_tick(output ev_t obs);
        obs     = '0;
        obs.gap = 8'hFF;
        for (int i = 1; i <= 64; i++) begin
            step(1);
            if (counter_update === 1'b1) begin
                obs.gap = 8'(i);
                obs.cnt = counter_out;
                obs.ex  = expired;
                obs.wt  = write_tick;
                return;
            end
            if (expired !== 1'b0 || write_tick !== 1'b0) obs.stray = obs.stray + 8'd1;
        end
    endtask

    task automatic set_idle();
        en = 1'b1; speed = 2'd0; mode_down = 1'b0; wrap_en = 1'b0;
        load = 1'b0; load_val = 4'd0; write = 1'b0;
    endtask

    task automatic do_reset();
        KEY0 = 1'b1;
        step(2);
        KEY0 = 1'b0;
    endtask

    task automatic test_reset();
        ev_t o, e;
        set_idle();
        write = 1'b1;              // write during reset must not be latched
        do_reset();
        write = 1'b0;
        total++;
        if ({counter_out, counter_update, write_tick, expired} !== 7'b0) begin
            bad++;
            $display("FAIL reset_state: got cnt=%0d upd=%b wt=%b ex=%b want 0 0 0 0",
                     counter_out, counter_update, write_tick, expired);
        end
        push(4'd1, 1'b0, 1'b0, 8);
        push(4'd2, 1'b0, 1'b0, 8);
        for (int k = 0; k < 2; k++) begin
            wait_tick(o);
            e = exp_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_run#%0d: got cnt=%0d ex=%b wt=%b gap=%0d stray=%0d want cnt=%0d ex=%b wt=%b gap=%0d",
                         k, o.cnt, o.ex, o.wt, o.gap, o.stray, e.cnt, e.ex, e.wt, e.gap);
            end
        end
        step(3);
        KEY0 = 1'b1;
        step(1);
        KEY0 = 1'b0;
        total++;
        if (counter_out !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid: got cnt=%0d want 0", counter_out);
        end
        push(4'd1, 1'b0, 1'b0, 8);
        wait_tick(o);
        e = exp_q.pop_front();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL reset_after: got cnt=%0d ex=%b wt=%b gap=%0d stray=%0d want cnt=%0d gap=%0d",
                     o.cnt, o.ex, o.wt, o.gap, o.stray, e.cnt, e.gap);
        end
    endtask

    task automatic test_speed();
        ev_t o, e;
        set_idle();
        do_reset();
        step(5);                   // prescaler now 5
        speed = 2'd2;              // period 2: 5 >= 1 ticks at once
        push(4'd1, 1'b0, 1'b0, 1);
        push(4'd2, 1'b0, 1'b0, 2);
        push(4'd3, 1'b0, 1'b0, 2);
        for (int k = 0; k < 3; k++) begin
            wait_tick(o);
            e = exp_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL speed#%0d: got cnt=%0d ex=%b wt=%b gap=%0d stray=%0d want cnt=%0d gap=%0d",
                         k, o.cnt, o.ex, o.wt, o.gap, o.stray, e.cnt, e.gap);
            end
        end
        speed = 2'd0;
    endtask

    task automatic test_up_terminal();
        ev_t o, e;
        set_idle();
        do_reset();
        load = 1'b1; load_val = 4'd14;
        step(1);
        load = 1'b0;
        push(4'd15, 1'b0, 1'b0, 8);
        push(4'd15, 1'b1, 1'b0, 8);
        push(4'd15, 1'b1, 1'b0, 8);
        push(4'd0,  1'b1, 1'b0, 8);
        push(4'd1,  1'b0, 1'b0, 8);
        for (int k = 0; k < 5; k++) begin
            if (k == 3) wrap_en = 1'b1;
            wait_tick(o);
            e = exp_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL up_term#%0d: got cnt=%0d ex=%b wt=%b gap=%0d stray=%0d want cnt=%0d ex=%b gap=%0d",
                         k, o.cnt, o.ex, o.wt, o.gap, o.stray, e.cnt, e.ex, e.gap);
            end
        end
    endtask

    task automatic test_down_terminal();
        ev_t o, e;
        set_idle();
        mode_down = 1'b1;
        do_reset();
        load = 1'b1; load_val = 4'd1;
        step(1);
        load = 1'b0;
        push(4'd0,  1'b0, 1'b0, 8);
        push(4'd0,  1'b1, 1'b0, 8);
        push(4'd15, 1'b1, 1'b0, 8);
        push(4'd14, 1'b0, 1'b0, 8);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) wrap_en = 1'b1;
            wait_tick(o);
            e = exp_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL down_term#%0d: got cnt=%0d ex=%b wt=%b gap=%0d stray=%0d want cnt=%0d ex=%b gap=%0d",
                         k, o.cnt, o.ex, o.wt, o.gap, o.stray, e.cnt, e.ex, e.gap);
            end
        end
    endtask

    task automatic test_write_latch();
        ev_t o, e;
        set_idle();
        do_reset();
        push(4'd1, 1'b0, 1'b0, 8);  // plain tick to align phase
        push(4'd2, 1'b0, 1'b1, 2);  // three writes collapse into one strobe
        push(4'd3, 1'b0, 1'b1, 1);  // write on the tick cycle itself
        push(4'd4, 1'b0, 1'b0, 8);  // not carried over
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                write = 1'b1; step(1); write = 1'b0; step(1);
                write = 1'b1; step(1); write = 1'b0; step(1);
                write = 1'b1; step(1); write = 1'b0; step(1);
            end else if (k == 2) begin
                step(7);
                write = 1'b1;
            end
            wait_tick(o);
            write = 1'b0;
            e = exp_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL write#%0d: got cnt=%0d ex=%b wt=%b gap=%0d stray=%0d want cnt=%0d wt=%b gap=%0d",
                         k, o.cnt, o.ex, o.wt, o.gap, o.stray, e.cnt, e.wt, e.gap);
            end
        end
    endtask

    task automatic test_pause_load();
        ev_t o, e;
        logic [3:0] c0;
        int viol;
        set_idle();
        do_reset();
        step(3);
        write = 1'b1; step(1); write = 1'b0;   // prescaler 4, write pending
        en = 1'b0;
        c0 = counter_out;
        viol = 0;
        repeat (20) begin
            step(1);
            if (counter_update !== 1'b0 || write_tick !== 1'b0 || expired !== 1'b0 || counter_out !== c0)
                viol++;
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL pause_hold: got %0d disturbed cycles want 0", viol);
        end
        en = 1'b1;
        push(4'd1,  1'b0, 1'b1, 4);   // remaining prescale 4..7
        push(4'd10, 1'b0, 1'b1, 8);   // after load of 9 on a tick cycle
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                write = 1'b1; step(1); write = 1'b0;
                step(6);                // prescaler 7: next edge would tick
                load = 1'b1; load_val = 4'd9;
                step(1);
                load = 1'b0;
                total++;
                if ({counter_out, counter_update, write_tick, expired} !== {4'd9, 3'b000}) begin
                    bad++;
                    $display("FAIL load_on_tick: got cnt=%0d upd=%b wt=%b ex=%b want 9 0 0 0",
                             counter_out, counter_update, write_tick, expired);
                end
            end
            wait_tick(o);
            e = exp_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL pause_load#%0d: got cnt=%0d ex=%b wt=%b gap=%0d stray=%0d want cnt=%0d wt=%b gap=%0d",
                         k, o.cnt, o.ex, o.wt, o.gap, o.stray, e.cnt, e.wt, e.gap);
            end
        end
    endtask

    initial begin
        KEY0 = 1'b1;
        set_idle();
        test_reset();
        test_speed();
        test_up_terminal();
        test_down_terminal();
        test_write_latch();
        test_pause_load();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
